// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared seven-segment definitions: digit count, segment bit order,
// slot FSM states and the hex glyph table.
package ssd_scan_ctrl_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned SEG_W      = 7;

   // Segment bit positions within a glyph (bit0 = a ... bit6 = g).
   localparam int unsigned SEG_A = 0;
   localparam int unsigned SEG_B = 1;
   localparam int unsigned SEG_C = 2;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 4;
   localparam int unsigned SEG_F = 5;
   localparam int unsigned SEG_G = 6;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } slot_state_t;

   // Active-high glyphs, bit order gfedcba.
   function automatic logic [SEG_W-1:0] hex_glyph(input logic [NIB_W-1:0] nib);
      logic [SEG_W-1:0] g;
      case (nib)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         default: g = 7'h71;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/ssd_decode_hex.sv
// Combinational hex nibble to seven-segment glyph decoder.
module ssd_decode_hex
   import ssd_scan_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0] nibble,
   output logic [SEG_W-1:0] seg
);

   // Table lookup from the shared glyph function.
   always_comb begin
      seg = hex_glyph(nibble);
   end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with per-slot
// anti-ghost blanking, leading-zero suppression and frame-aligned
// double-buffered display data.
module ssd_scan_ctrl
   import ssd_scan_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 16000000,
   parameter int unsigned SLOT_HZ      = 1000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_DIGITS*NIB_W-1:0] value,
   input  logic                        load,
   input  logic [NUM_DIGITS-1:0]       dp,
   input  logic                        blank_lz,
   input  logic [NUM_DIGITS-1:0]       digit_en,
   output logic [SEG_W-1:0]            seg,
   output logic                        seg_dp,
   output logic [NUM_DIGITS-1:0]       dig_sel,
   output logic                        frame_done
);

   localparam int unsigned DIV = CLK_HZ / SLOT_HZ;
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

   if (DIV <= BLANK_CYCLES || DIV < 2) begin : g_bad_div
      $error("ssd_scan_ctrl: slot length must exceed BLANK_CYCLES and be at least 2");
   end

   slot_state_t                  state;
   logic [CW-1:0]                cnt;
   logic [CW-1:0]                cnt_nxt;
   logic [1:0]                   idx;

   logic [NUM_DIGITS*NIB_W-1:0]  pend_val;
   logic [NUM_DIGITS-1:0]        pend_dp;
   logic                         pend_lz;
   logic [NUM_DIGITS*NIB_W-1:0]  act_val;
   logic [NUM_DIGITS-1:0]        act_dp;
   logic                         act_lz;

   logic                         last;
   logic                         wrap;
   logic                         suppress;
   logic                         visible;
   logic [NIB_W-1:0]             nib;
   logic [NUM_DIGITS*NIB_W-1:0]  upper;
   logic [SEG_W-1:0]             glyph;

   // Slot position decode and visibility of the current digit.
   always_comb begin
      last     = (cnt == CW'(DIV - 1));
      wrap     = last && (idx == 2'd3);
      cnt_nxt  = last ? '0 : cnt + 1'b1;
      nib      = act_val[{idx, 2'b00} +: NIB_W];
      // Current nibble and everything above it, shifted down.
      upper    = act_val >> {idx, 2'b00};
      suppress = act_lz && (idx != 2'd0) && !act_dp[idx] && (upper == '0);
      visible  = (state == ST_SHOW) && digit_en[idx] && !suppress;
   end

   ssd_decode_hex u_decode (
      .nibble (nib),
      .seg    (glyph)
   );

   // Slot FSM, divider, display buffers and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_BLANK;
         cnt        <= '0;
         idx        <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_lz    <= 1'b0;
         act_val    <= '0;
         act_dp     <= '0;
         act_lz     <= 1'b0;
         seg        <= '0;
         seg_dp     <= 1'b0;
         dig_sel    <= '0;
         frame_done <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (last) begin
            idx <= idx + 2'd1;
         end
         state <= (cnt_nxt < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_SHOW;

         // Outputs reflect the state held during this cycle.
         seg        <= visible ? glyph : '0;
         seg_dp     <= visible && act_dp[idx];
         dig_sel    <= visible ? (4'b0001 << idx) : '0;
         // Registered one cycle early so the pulse lands on the wrap cycle.
         frame_done <= (cnt == CW'(DIV - 2)) && (idx == 2'd3);

         if (wrap) begin
            if (load) begin
               act_val <= value;
               act_dp  <= dp;
               act_lz  <= blank_lz;
            end else begin
               act_val <= pend_val;
               act_dp  <= pend_dp;
               act_lz  <= pend_lz;
            end
         end
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp;
            pend_lz  <= blank_lz;
         end
      end
   end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl with a time-based reference model.
module tb_ssd_scan_ctrl;

   localparam int unsigned CLK_HZ  = 100;
   localparam int unsigned SLOT_HZ = 10;
   localparam int unsigned BLANK   = 2;
   localparam int unsigned DIV     = CLK_HZ / SLOT_HZ;
   localparam int unsigned FRAME   = 4 * DIV;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] value = '0;
   logic        load = 1'b0;
   logic [3:0]  dp = '0;
   logic        blank_lz = 1'b0;
   logic [3:0]  digit_en = 4'hF;
   logic [6:0]  seg;
   logic        seg_dp;
   logic [3:0]  dig_sel;
   logic        frame_done;

   always #5 CLK = ~CLK;

   ssd_scan_ctrl #(
      .CLK_HZ       (CLK_HZ),
      .SLOT_HZ      (SLOT_HZ),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .value      (value),
      .load       (load),
      .dp         (dp),
      .blank_lz   (blank_lz),
      .digit_en   (digit_en),
      .seg        (seg),
      .seg_dp     (seg_dp),
      .dig_sel    (dig_sel),
      .frame_done (frame_done)
   );

   int checks   = 0;
   int failures = 0;

   logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Reference model: t = clock edges since reset release.
   int unsigned t;
   int          cyc;
   int          last_fd;
   logic [15:0] a_val, p_val;
   logic [3:0]  a_dp, p_dp;
   logic        a_lz, p_lz;
   logic [6:0]  e_seg;
   logic        e_sdp;
   logic [3:0]  e_dig;
   logic        e_fd;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic bit wrap_at(input int unsigned tt);
      return ((tt % DIV) == DIV - 1) && (((tt / DIV) % 4) == 3);
   endfunction

   function automatic bit dark(input int unsigned n, input logic [15:0] v,
                               input logic [3:0] d, input logic lz);
      return lz && (n != 0) && !d[n] && ((v >> (4 * n)) == 16'h0);
   endfunction

   task automatic model_reset();
      t = 0; last_fd = -1;
      a_val = '0; p_val = '0; a_dp = '0; p_dp = '0; a_lz = 0; p_lz = 0;
      e_seg = '0; e_sdp = 0; e_dig = '0; e_fd = 0;
   endtask

   task automatic model_edge();
      int unsigned slot_cyc, n;
      bit vis;
      slot_cyc = t % DIV;
      n        = (t / DIV) % 4;
      vis      = (slot_cyc >= BLANK) && digit_en[n] && !dark(n, a_val, a_dp, a_lz);
      e_seg    = vis ? glyph_tab[a_val[4*n +: 4]] : 7'h00;
      e_sdp    = vis && a_dp[n];
      e_dig    = vis ? 4'(1 << n) : 4'h0;
      if (wrap_at(t)) begin
         a_val = load ? value : p_val;
         a_dp  = load ? dp : p_dp;
         a_lz  = load ? blank_lz : p_lz;
      end
      if (load) begin
         p_val = value; p_dp = dp; p_lz = blank_lz;
      end
      t++;
      e_fd = wrap_at(t);
   endtask

   // One clock: advance the model with the held inputs, then compare at negedge.
   task automatic tick();
      model_edge();
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      check("cyc", {3'b000, seg, seg_dp, dig_sel, frame_done}, {3'b000, e_seg, e_sdp, e_dig, e_fd});
      if (frame_done) begin
         if (last_fd >= 0) check("frame_period", 16'(cyc - last_fd), 16'(FRAME));
         last_fd = cyc;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Tick until the model's current cycle is the 3->0 wrap cycle.
   task automatic run_to_wrap();
      for (int i = 0; i < 2 * FRAME && !wrap_at(t); i++) tick();
      check("wrap_reached", 16'(wrap_at(t)), 16'd1);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
      value = v; dp = d; blank_lz = lz; load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      cyc = 0;
      model_reset();
      repeat (2) @(negedge CLK);
      check("rst_out", {3'b000, seg, seg_dp, dig_sel, frame_done}, 16'h0);
      RST = 1'b0;

      // Basic scan of 0x1234, all digits enabled.
      do_load(16'h1234, 4'h0, 1'b0);
      run_to_wrap();
      ticks(4);
      check("d0_glyph4", {9'h0, seg}, 16'h0066);
      check("d0_sel", {12'h0, dig_sel}, 16'h0001);
      ticks(2 * FRAME);

      // Leading-zero suppression, then with dp on digit 3.
      do_load(16'h0050, 4'h0, 1'b1);
      run_to_wrap();
      ticks(FRAME + 1);
      do_load(16'h0050, 4'b1000, 1'b1);
      run_to_wrap();
      ticks(FRAME + 1);

      // Mid-frame load takes effect only from the next frame.
      ticks(15);
      do_load(16'hAAAA, 4'h0, 1'b0);
      run_to_wrap();
      ticks(FRAME + 1);

      // Load exactly on the wrap cycle.
      run_to_wrap();
      do_load(16'hBEEF, 4'h0, 1'b0);
      ticks(3);
      check("beef_d0", {9'h0, seg}, 16'h0071);
      ticks(FRAME);

      // Disabled digits 1 and 3.
      digit_en = 4'b0101;
      ticks(2 * FRAME);
      digit_en = 4'hF;

      // Randomised loads, digit enables and leading zeros.
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            value    = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            blank_lz = ($urandom_range(0, 3) != 0);
            load     = 1'b1;
         end
         if ($urandom_range(0, 63) == 0) digit_en = 4'($urandom);
         tick();
         load = 1'b0;
      end
      digit_en = 4'hF;

      // Asynchronous reset in SHOW cycle 5 of digit 2.
      do_load(16'h1234, 4'h0, 1'b0);
      run_to_wrap();
      ticks(1 + 2 * DIV + BLANK + 5);
      check("pre_rst_sel", {12'h0, dig_sel}, 16'h0004);
      #2 RST = 1'b1;
      #1 check("rst_async", {3'b000, seg, seg_dp, dig_sel, frame_done}, 16'h0);
      @(negedge CLK);
      RST = 1'b0;
      model_reset();
      ticks(BLANK);
      check("post_rst_blank", {12'h0, dig_sel}, 16'h0);
      tick();
      check("post_rst_d0", {12'h0, dig_sel}, 16'h0001);
      ticks(FRAME);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 16000000, meaning input clock frequency in Hz.
REQ-002 The block SHALL have parameter SLOT_HZ, default 1000, meaning digit-slot rate; slot length DIV = CLK_HZ/SLOT_HZ cycles.
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 16, meaning anti-ghost blank cycles at the start of each slot.
REQ-004 The block SHALL have port CLK  input  1  system clock, all logic on posedge.
REQ-005 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port value  input  16  four hex digits; digit n = value[4n+3:4n].
REQ-007 The block SHALL have port load  input  1  single-cycle strobe capturing value, dp and blank_lz.
REQ-008 The block SHALL have port dp  input  4  decimal point per digit.
REQ-009 The block SHALL have port blank_lz  input  1  leading-zero suppression enable.
REQ-010 The block SHALL have port digit_en  input  4  per-digit enable, sampled live.
REQ-011 The block SHALL have port seg  output  7  segments a..g (bit0 = a), active-high.
REQ-012 The block SHALL have port seg_dp  output  1  decimal-point segment, active-high.
REQ-013 The block SHALL have port dig_sel  output  4  one-hot digit select, active-high.
REQ-014 The block SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-015 The block SHALL divide time into slots of exactly DIV cycles, with digit index 0,1,2,3 repeating.
REQ-016 The slot FSM SHALL have two states: BLANK for slot cycles 0..BLANK_CYCLES-1, then SHOW for cycles BLANK_CYCLES..DIV-1.
REQ-017 At the end of SHOW the FSM SHALL go to BLANK and increment the index mod 4.
REQ-018 In BLANK, dig_sel, seg and seg_dp SHALL all be 0.
REQ-019 In SHOW, dig_sel SHALL be one-hot at the current index, and seg/seg_dp SHALL show the hex glyph and dp bit of the active digit.
REQ-020 seg, seg_dp and dig_sel SHALL be registered, lagging the FSM state by exactly 1 cycle.
REQ-021 A slot whose digit_en bit is 0 SHALL keep dig_sel, seg and seg_dp at 0 for the whole slot, with slot timing unchanged.
REQ-022 Digits 3..1 SHALL be suppressed (dig_sel 0) when active blank_lz=1, the digit nibble is 0 and all higher nibbles are 0. Digit 0 SHALL never be suppressed. A digit with its dp bit set SHALL not be suppressed.
REQ-023 Double-buffering: load SHALL write the pending registers. At the 3->0 index wrap, active SHALL take pending. If load coincides with the wrap cycle, active SHALL take the load-cycle inputs directly.
REQ-024 frame_done SHALL pulse high for 1 cycle on the cycle the index wraps 3->0.
REQ-025 Multiple loads within one frame SHALL keep only the last.

Reset
REQ-026 RST high SHALL immediately force seg=0, seg_dp=0, dig_sel=0 and frame_done=0, asynchronously, including mid-slot.
REQ-027 RST high SHALL clear the slot counter and index to 0, set state to BLANK, and clear pending and active registers to 0.
REQ-028 After RST deasserts, the first slot SHALL be digit 0 starting in BLANK with the counter at 0.

Structure
REQ-029 The glyph table and the shared constants (digit count 4, segment bit order) SHALL live in the shared SSD include file used by the hex decoder.
REQ-030 Glyph decoding SHALL instantiate the existing ssd_decode_hex sub-module; the scan FSM, divider and buffers SHALL be local.
REQ-031 Elaboration SHALL fail if DIV <= BLANK_CYCLES or DIV < 2.

Verification (CLK_HZ=100, SLOT_HZ=10 -> DIV=10, BLANK_CYCLES=2)
REQ-032 Reset release, value=0x1234 loaded, digit_en=F: dig_sel must follow 0000 x2, 0001 x8, 0000 x2, 0010 x8, etc. In slot 0, seg must be the glyph for 4, and frame_done must pulse every 40 cycles.
REQ-033 value=0x0050 with blank_lz=1: digits 3 and 2 must stay dark, and digits 1 and 0 must show 5 and 0. With dp=0b1000, digit 3 must show 0 with dp lit.
REQ-034 Load 0xAAAA mid-frame: the current frame must continue showing the old value, and 0xAAAA must appear starting from the frame after frame_done.
REQ-035 Load 0xBEEF on the wrap cycle: the new frame's digit 0 must show F.
REQ-036 digit_en=0b0101: the slots for digits 1 and 3 must be dark while the frame period stays 40 cycles.
REQ-037 RST asserted at SHOW cycle 5 of digit 2: outputs must be 0 in the same cycle, and the first post-reset slot must be digit 0 with BLANK for 2 cycles.
